// File: rtl/ca_pkg.sv
// ca_pkg: shared constants, G2 tap table, state type and chip helper for ca_code_gen
package ca_pkg;
    localparam int CA_CHIPS = 1023;
    localparam int CA_MS_PER_BIT = 20;
    localparam logic [5:0] PRN_MIN = 6'd1;
    localparam logic [5:0] PRN_MAX = 6'd32;
    // Feedback masks: bit i-1 set means stage i is a feedback tap
    localparam logic [9:0] G1_MASK = 10'h204;
    localparam logic [9:0] G2_MASK = 10'h3A6;
    typedef enum logic [1:0] {IDLE, ARMED, RUN} ca_state_t;
    // {s1, s2} G2 phase-selector taps per PRN
    localparam logic [7:0] G2_TAPS [1:32] = '{
        8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
        8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
        8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
        8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
    };
    function automatic logic ca_chip(input logic [9:0] g1, input logic [9:0] g2, input logic [7:0] taps);
        return g1[9] ^ g2[taps[7:4] - 4'd1] ^ g2[taps[3:0] - 4'd1];
    endfunction
endpackage

// File: rtl/ca_code_gen_if.sv
// ca_code_gen_if: strobe/restart inputs and code replica outputs of ca_code_gen
// Optional: CA_BIT_SYNC_EN adds ms_cnt and bit_edge.
interface ca_code_gen_if;
    logic       strobe_0;
    logic       strobe_180;
    logic       restart;
    logic [5:0] prn;
    logic       code_p;
    logic       code_e;
    logic       code_l;
    logic       epoch;
    logic [9:0] chip_idx;
    logic       running;
    logic       err;
`ifdef CA_BIT_SYNC_EN
    logic [4:0] ms_cnt;
    logic       bit_edge;
`endif
    modport master (
        output strobe_0, strobe_180, restart, prn,
        input  code_p, code_e, code_l, epoch, chip_idx, running, err
`ifdef CA_BIT_SYNC_EN
        , input ms_cnt, bit_edge
`endif
    );
    modport slave (
        input  strobe_0, strobe_180, restart, prn,
        output code_p, code_e, code_l, epoch, chip_idx, running, err
`ifdef CA_BIT_SYNC_EN
        , output ms_cnt, bit_edge
`endif
    );
endinterface

// File: rtl/ca_lfsr10.sv
// ca_lfsr10: 10-bit Fibonacci LFSR with generic feedback mask
// Ports: clk_in, rst_n (async, active low), i_load (reload all ones), i_step (advance),
//   o_state (effective current state: all ones while i_load is high, else the register).
module ca_lfsr10 #(
    parameter logic [9:0] MASK = 10'h204
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_step,
    output logic [9:0] o_state
);
    logic [9:0] r_q;
    assign o_state = i_load ? '1 : r_q;
    // Load and step together advance one step from the all-ones state
    always_ff @(posedge clk_in or negedge rst_n)
        if (!rst_n) r_q <= '1;
        else if (i_step) r_q <= {o_state[8:0], ^(o_state & MASK)};
        else if (i_load) r_q <= '1;
endmodule

// File: rtl/ca_code_gen.sv
// ca_code_gen: GPS L1 C/A Gold-code generator with prompt, early and late replicas
// Ports: clk_in (16 MHz), rst_n (async, active low), bus (slave modport of ca_code_gen_if):
//   strobe_0/strobe_180 chip strobes, restart+prn re-arm, code_p/code_e/code_l, epoch,
//   chip_idx, running, err.
// Optional: CA_BIT_SYNC_EN adds bus.ms_cnt (epoch within data bit) and bus.bit_edge.
module ca_code_gen
    import ca_pkg::*;
#(
    parameter int CHIP_COUNT = CA_CHIPS
) (
    input logic          clk_in,
    input logic          rst_n,
    ca_code_gen_if.slave bus
);
    ca_state_t  r_state;
    logic [5:0] r_prn;
    logic       r_code_p, r_code_e, r_code_l, r_epoch, r_err;
    logic [9:0] r_chip_idx;
    logic [9:0] w_g1, w_g2;
    logic       w_prn_ok, w_s0, w_wrap, w_load, w_chip;
    assign w_prn_ok = bus.prn >= PRN_MIN && bus.prn <= PRN_MAX;
    // Any restart (valid or not) swallows the strobes of its cycle
    assign w_s0 = !bus.restart && bus.strobe_0 && r_state != IDLE;
    assign w_wrap = r_state == RUN && r_chip_idx == 10'(CHIP_COUNT - 1);
    assign w_load = (bus.restart && w_prn_ok) || (w_s0 && w_wrap);
    // LFSR outputs already reflect a same-cycle reload, so this is chip0 at the epoch
    assign w_chip = ca_chip(w_g1, w_g2, G2_TAPS[r_prn]);
    ca_lfsr10 #(.MASK(G1_MASK)) u_g1 (
        .clk_in(clk_in), .rst_n(rst_n), .i_load(w_load), .i_step(w_s0), .o_state(w_g1)
    );
    ca_lfsr10 #(.MASK(G2_MASK)) u_g2 (
        .clk_in(clk_in), .rst_n(rst_n), .i_load(w_load), .i_step(w_s0), .o_state(w_g2)
    );
`ifdef CA_BIT_SYNC_EN
    logic [4:0] r_ms_cnt;
    logic       r_bit_edge;
    assign bus.ms_cnt = r_ms_cnt;
    assign bus.bit_edge = r_bit_edge;
`endif
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_prn <= 6'd1;
            r_code_p <= 1'b0;
            r_code_e <= 1'b0;
            r_code_l <= 1'b0;
            r_epoch <= 1'b0;
            r_err <= 1'b0;
            r_chip_idx <= '0;
`ifdef CA_BIT_SYNC_EN
            r_ms_cnt <= '0;
            r_bit_edge <= 1'b0;
`endif
        end else begin
            r_epoch <= 1'b0;
`ifdef CA_BIT_SYNC_EN
            r_bit_edge <= 1'b0;
`endif
            if (bus.restart) begin
                r_err <= !w_prn_ok;
                if (w_prn_ok) begin
                    r_state <= ARMED;
                    r_prn <= bus.prn;
                    r_code_p <= 1'b0;
                    r_code_e <= 1'b0;
                    r_code_l <= 1'b0;
                    r_chip_idx <= '0;
`ifdef CA_BIT_SYNC_EN
                    r_ms_cnt <= '0;
`endif
                end
            end else if (r_state != IDLE) begin
                if (bus.strobe_0 && bus.strobe_180) r_err <= 1'b1;
                if (bus.strobe_0) begin
                    r_code_p <= w_chip;
                    r_epoch <= r_state == ARMED || w_wrap;
                    r_chip_idx <= r_state == ARMED || w_wrap ? '0 : r_chip_idx + 10'd1;
                    if (r_state == ARMED) begin
                        r_code_e <= w_chip;
                        r_code_l <= 1'b0;
                        r_state <= RUN;
                    end
`ifdef CA_BIT_SYNC_EN
                    if (r_state == ARMED) begin
                        r_ms_cnt <= '0;
                        r_bit_edge <= 1'b1;
                    end else if (w_wrap) begin
                        r_ms_cnt <= r_ms_cnt == 5'(CA_MS_PER_BIT - 1) ? '0 : r_ms_cnt + 5'd1;
                        r_bit_edge <= r_ms_cnt == 5'(CA_MS_PER_BIT - 1);
                    end
`endif
                end else if (bus.strobe_180 && r_state == RUN) begin
                    r_code_l <= r_code_p;
                    r_code_e <= w_chip;
                end
            end
        end
    end
    assign bus.code_p = r_code_p;
    assign bus.code_e = r_code_e;
    assign bus.code_l = r_code_l;
    assign bus.epoch = r_epoch;
    assign bus.chip_idx = r_chip_idx;
    assign bus.running = r_state == RUN;
    assign bus.err = r_err;
endmodule

// File: tb/tb_ca_code_gen.sv
// tb_ca_code_gen: randomized self-checking bench against a chip-table model of the C/A generator
module tb_ca_code_gen;
    logic clk_in = 1'b0;
    logic rst_n = 1'b0;
    ca_code_gen_if bus();
    ca_code_gen dut (.clk_in(clk_in), .rst_n(rst_n), .bus(bus));
    always #5 clk_in = ~clk_in;

    int n_vec = 0, n_err = 0;
    bit g1 [0:1032];
    bit g2 [0:1032];
    bit code_tab [1:32][0:1022];
    int delay_tab [1:32] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256, 257, 258,
                             469, 470, 471, 472, 473, 474, 509, 512, 513, 514, 515, 516, 859, 860, 861, 862};

    int m_state, m_prn, m_k, m_nk, m_nep;
    bit m_p, m_e, m_l, m_ep, m_err;
    int cyc = 0, ep_cnt = 0, ep_last = 0, ep_gap = 0, be_cnt = 0;
    bit cp;
    logic [9:0] v;
    bit seq [0:2045];
    int diffs;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] first10(input int p);
        logic [9:0] r = '0;
        for (int i = 0; i < 10; i++) r = {r[8:0], code_tab[p][i]};
        return r;
    endfunction

    // Model: code advances as an index into the per-PRN chip table
    assign m_nk = (m_state == 1) ? 0 : (m_k + 1) % 1023;
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0; m_prn <= 1; m_k <= 0; m_nep <= 0;
            m_p <= 0; m_e <= 0; m_l <= 0; m_ep <= 0; m_err <= 0;
        end else begin
            m_ep <= 0;
            if (bus.restart) begin
                if (bus.prn >= 1 && bus.prn <= 32) begin
                    m_state <= 1; m_prn <= int'(bus.prn); m_k <= 0; m_nep <= 0;
                    m_p <= 0; m_e <= 0; m_l <= 0; m_err <= 0;
                end else m_err <= 1;
            end else if (m_state != 0) begin
                if (bus.strobe_0 && bus.strobe_180) m_err <= 1;
                if (bus.strobe_0) begin
                    m_k <= m_nk;
                    m_p <= code_tab[m_prn][m_nk];
                    m_ep <= (m_nk == 0);
                    if (m_nk == 0) m_nep <= m_nep + 1;
                    if (m_state == 1) begin
                        m_e <= code_tab[m_prn][0];
                        m_l <= 0;
                        m_state <= 2;
                    end
                end else if (bus.strobe_180 && m_state == 2) begin
                    m_l <= m_p;
                    m_e <= code_tab[m_prn][(m_k + 1) % 1023];
                end
            end
        end
    end

    always @(negedge clk_in) begin
        check("code_p", bus.code_p, m_p);
        check("code_e", bus.code_e, m_e);
        check("code_l", bus.code_l, m_l);
        check("epoch", bus.epoch, m_ep);
        check("chip_idx", bus.chip_idx, m_k);
        check("running", bus.running, m_state == 2);
        check("err", bus.err, m_err);
`ifdef CA_BIT_SYNC_EN
        check("ms_cnt", bus.ms_cnt, m_nep == 0 ? 0 : (m_nep - 1) % 20);
        check("bit_edge", bus.bit_edge, m_ep && m_nep > 0 && (m_nep - 1) % 20 == 0);
        if (bus.bit_edge) be_cnt++;
`endif
        cyc++;
        if (bus.epoch) begin
            ep_cnt++;
            ep_gap = cyc - ep_last;
            ep_last = cyc;
        end
    end

    task automatic do_chip(input int gap, output bit c);
        bus.strobe_0 = 1'b1;
        @(negedge clk_in);
        bus.strobe_0 = 1'b0;
        c = bus.code_p;
        repeat (gap / 2 - 1) @(negedge clk_in);
        bus.strobe_180 = 1'b1;
        @(negedge clk_in);
        bus.strobe_180 = 1'b0;
        repeat (gap / 2 - 1) @(negedge clk_in);
    endtask

    task automatic do_restart(input int p);
        bus.prn = 6'(p);
        bus.restart = 1'b1;
        @(negedge clk_in);
        bus.restart = 1'b0;
    endtask

    initial begin
        for (int n = 0; n < 10; n++) begin g1[n] = 1; g2[n] = 1; end
        for (int n = 0; n < 1023; n++) begin
            g1[n + 10] = g1[n + 7] ^ g1[n];
            g2[n + 10] = g2[n + 8] ^ g2[n + 7] ^ g2[n + 4] ^ g2[n + 2] ^ g2[n + 1] ^ g2[n];
        end
        for (int p = 1; p <= 32; p++)
            for (int i = 0; i < 1023; i++)
                code_tab[p][i] = g1[i] ^ g2[(i + 1023 - delay_tab[p]) % 1023];
        check("model_prn1", first10(1), 10'o1440);
        check("model_prn2", first10(2), 10'o1620);
        bus.strobe_0 = 0; bus.strobe_180 = 0; bus.restart = 0; bus.prn = 0;
        repeat (3) @(negedge clk_in);
        check("rst_code_p", bus.code_p, 0);
        check("rst_chip_idx", bus.chip_idx, 0);
        check("rst_running", bus.running, 0);
        rst_n = 1'b1;
        repeat (6) begin
            bus.strobe_0 = 1'($urandom_range(1));
            bus.strobe_180 = 1'($urandom_range(1));
            @(negedge clk_in);
        end
        bus.strobe_0 = 0; bus.strobe_180 = 0;
        check("idle_running", bus.running, 0);
        do_restart(1);
        check("armed_running", bus.running, 0);
        ep_cnt = 0;
        v = '0;
        for (int i = 0; i < 10; i++) begin do_chip(4, cp); v = {v[8:0], cp}; end
        check("prn1_first10", v, 10'o1440);
        check("prn1_epochs", ep_cnt, 1);
        do_restart(2);
        v = '0;
        for (int i = 0; i < 10; i++) begin do_chip(4, cp); v = {v[8:0], cp}; end
        check("prn2_first10", v, 10'o1620);
        do_restart(1);
        ep_cnt = 0;
        for (int i = 0; i < 2046; i++) begin
            do_chip(16, cp);
            seq[i] = cp;
            if (i == 1022) check("idx_last", bus.chip_idx, 1022);
            if (i == 1023) check("idx_wrap", bus.chip_idx, 0);
        end
        check("freerun_epochs", ep_cnt, 2);
        check("epoch_gap", ep_gap, 1023 * 16);
        diffs = 0;
        for (int i = 0; i < 1023; i++) if (seq[i] != seq[i + 1023]) diffs++;
        check("period_repeat", diffs, 0);
        do_restart(0);
        check("prn0_err", bus.err, 1);
        check("prn0_running", bus.running, 1);
        check("prn0_idx", bus.chip_idx, 1022);
        do_restart(33);
        check("prn33_err", bus.err, 1);
        do_chip(4, cp);
        do_restart(5);
        check("prn5_err", bus.err, 0);
        check("prn5_running", bus.running, 0);
        do_chip(4, cp);
        bus.strobe_0 = 1; bus.strobe_180 = 1;
        @(negedge clk_in);
        bus.strobe_0 = 0; bus.strobe_180 = 0;
        check("both_strobes_err", bus.err, 1);
        check("both_strobes_idx", bus.chip_idx, 1);
        bus.strobe_0 = 1;
        do_restart(7);
        bus.strobe_0 = 0;
        check("restart_wins_running", bus.running, 0);
        check("restart_wins_err", bus.err, 0);
        for (int c = 0; c < 3000; c++) begin
            bus.strobe_0 = ($urandom_range(3) == 0);
            bus.strobe_180 = ($urandom_range(3) == 0);
            bus.restart = ($urandom_range(63) == 0);
            bus.prn = 6'($urandom_range(40));
            @(negedge clk_in);
        end
        bus.strobe_0 = 0; bus.strobe_180 = 0; bus.restart = 0;
        do_restart(9);
        for (int i = 0; i < 5; i++) do_chip(4, cp);
        @(posedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        check("async_code_p", bus.code_p, 0);
        check("async_code_e", bus.code_e, 0);
        check("async_code_l", bus.code_l, 0);
        check("async_idx", bus.chip_idx, 0);
        check("async_running", bus.running, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        do_restart(9);
        for (int i = 0; i < 5; i++) do_chip(4, cp);
`ifdef CA_BIT_SYNC_EN
        do_restart(3);
        be_cnt = 0;
        repeat (21 * 1023) do_chip(2, cp);
        check("bit_edges", be_cnt, 2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
